// File: rtl/digi_pot_spi_writer.sv
`default_nettype none
// ============================================================================
//  Module   : digi_pot_spi_writer
//  Purpose  : Sends the digi_pot wiper value to an external digital
//             potentiometer over 3-wire SPI (mode 0, MSB first). One 16-bit
//             frame {CMD_BYTE, wiper} goes out whenever wiper_in differs from
//             the last value sent, plus one forced frame after reset. Values
//             that change while a frame is in flight are coalesced: only the
//             value present when the writer returns to idle is sent next.
//  Ports    : clk       - system clock, rising edge
//             reset     - synchronous, active-high reset
//             wiper_in  - 8-bit wiper value
//             sclk      - SPI clock, idles low
//             mosi      - SPI data out, MSB first
//             cs_n      - SPI chip select, active low
//             busy      - frame or post-frame gap in progress
//             done      - one-cycle pulse when frame and gap complete
//  Revision : 1.0 - initial release
// ============================================================================
module digi_pot_spi_writer #(
  parameter int         CLK_DIV  = 4,      // SCLK half-period H in clk cycles
  parameter logic [7:0] CMD_BYTE = 8'h11   // command byte, frame bits [15:8]
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wiper_in,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [4:0]  LAST_BIT = 5'd15;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shadow;
  logic [15:0] shadow_next;
  logic [7:0]  last_sent;
  logic        init_pend;

  logic        div_last;
  logic        start;
  logic        in_frame_next;
  logic        sclk_next;
  logic        mosi_next;
  logic        cs_n_next;
  logic        busy_next;
  logic        done_next;

  assign div_last = (div_cnt == DIV_LAST);
  assign start    = (state == ST_IDLE) && (init_pend || (wiper_in != last_sent));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: every non-idle state lasts exactly H cycles
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (div_last) state_next = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (div_last) state_next = (bit_cnt == LAST_BIT) ? ST_HOLD : ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (div_last) state_next = ST_SHIFT_HI;
      end
      ST_HOLD: begin
        if (div_last) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (div_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift register: loaded at start, advanced when SCLK falls so the next bit
  // appears on mosi a full half-period before the following rising edge.
  // After bit 0 it is left alone so mosi holds through HOLD.
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_next = shadow;
    if (start) begin
      shadow_next = {CMD_BYTE, wiper_in};
    end else if ((state == ST_SHIFT_HI) && div_last && (bit_cnt != LAST_BIT)) begin
      shadow_next = {shadow[14:0], 1'b0};
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shadow    <= '0;
      last_sent <= '0;
      init_pend <= 1'b1;
    end else begin
      // Divider restarts on every state change so each state spans H cycles.
      if ((state == ST_IDLE) || (state_next != state)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end

      shadow <= shadow_next;

      if (start) begin
        bit_cnt   <= '0;
        last_sent <= wiper_in;
        init_pend <= 1'b0;
      end else if ((state == ST_SHIFT_HI) && div_last) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: decoded from the upcoming state and registered so the SPI
  // pins come straight from flops and cannot glitch.
  // --------------------------------------------------------------------------
  always_comb begin
    in_frame_next = (state_next == ST_SETUP) || (state_next == ST_SHIFT_HI) ||
                    (state_next == ST_SHIFT_LO) || (state_next == ST_HOLD);
    cs_n_next = !in_frame_next;
    sclk_next = (state_next == ST_SHIFT_HI);
    mosi_next = in_frame_next && shadow_next[15];
    busy_next = (state_next != ST_IDLE);
    done_next = (state == ST_GAP) && div_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cs_n <= cs_n_next;
      sclk <= sclk_next;
      mosi <= mosi_next;
      busy <= busy_next;
      done <= done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digi_pot_spi_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digi_pot_spi_writer
//  Purpose  : Self-checking bench for digi_pot_spi_writer. Two instances run
//             side by side (H=2 / CMD 8'h11 and H=1 / CMD 8'hA5). A reference
//             model predicts frame starts, busy/done/cs_n timing and pushes
//             expected frames into a queue; a monitor decodes the SPI pins
//             and checks against the queue and per-cycle expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_digi_pot_spi_writer;

  localparam int         H0   = 2;
  localparam int         H1   = 1;
  localparam logic [7:0] CMD0 = 8'h11;
  localparam logic [7:0] CMD1 = 8'hA5;

  logic       clk;
  logic       rst0 = 1'b1;
  logic       rst1 = 1'b1;
  logic [7:0] w0   = 8'd128;
  logic [7:0] w1   = 8'h3C;
  logic       sclk0, mosi0, cs_n0, busy0, done0;
  logic       sclk1, mosi1, cs_n1, busy1, done1;

  digi_pot_spi_writer #(.CLK_DIV(H0), .CMD_BYTE(CMD0)) dut0 (
    .clk(clk), .reset(rst0), .wiper_in(w0),
    .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0), .busy(busy0), .done(done0)
  );

  digi_pot_spi_writer #(.CLK_DIV(H1), .CMD_BYTE(CMD1)) dut1 (
    .clk(clk), .reset(rst1), .wiper_in(w1),
    .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Reference model state
  bit          pend   [2] = '{1'b1, 1'b1};
  logic [7:0]  last   [2] = '{8'd0, 8'd0};
  int          rem    [2] = '{0, 0};
  bit          e_busy [2] = '{1'b0, 1'b0};
  bit          e_done [2] = '{1'b0, 1'b0};
  bit          e_csn  [2] = '{1'b1, 1'b1};
  int          aborts [2] = '{0, 0};
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  // Monitor state
  int          seen   [2] = '{0, 0};
  bit          in_fr  [2] = '{1'b0, 1'b0};
  int          nb     [2] = '{0, 0};
  logic [15:0] bits   [2];
  bit          psclk  [2] = '{1'b0, 1'b0};

  task automatic cmp(input string nm, input int d, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Predicts the effect of the coming rising edge. A frame plus its gap
  // occupies 34H edges; cs_n is low for the first 33H of them.
  task automatic model_step(input int d, input logic r, input logic [7:0] w,
                            input int h, input logic [7:0] cmd);
    if (r) begin
      pend[d]   = 1'b1;
      last[d]   = 8'd0;
      rem[d]    = 0;
      e_busy[d] = 1'b0;
      e_done[d] = 1'b0;
      e_csn[d]  = 1'b1;
      aborts[d]++;
    end else if (rem[d] == 0) begin
      e_done[d] = 1'b0;
      if (pend[d] || (w != last[d])) begin
        if (d == 0) q0.push_back({cmd, w});
        else        q1.push_back({cmd, w});
        last[d]   = w;
        pend[d]   = 1'b0;
        rem[d]    = 34 * h;
        e_busy[d] = 1'b1;
        e_csn[d]  = 1'b0;
      end else begin
        e_busy[d] = 1'b0;
        e_csn[d]  = 1'b1;
      end
    end else begin
      rem[d]--;
      e_done[d] = (rem[d] == 0);
      e_busy[d] = (rem[d] != 0);
      e_csn[d]  = (rem[d] <= h);
    end
  endtask

  task automatic monitor(input int d, input logic cs_n, input logic sclk,
                         input logic mosi, input logic busy, input logic done);
    logic [15:0] exp;
    if (seen[d] != aborts[d]) begin
      seen[d] = aborts[d];
      if (in_fr[d]) begin
        in_fr[d] = 1'b0;
        if (d == 0 && q0.size() > 0) void'(q0.pop_front());
        if (d == 1 && q1.size() > 0) void'(q1.pop_front());
      end
    end
    cmp("busy", d, int'(busy), int'(e_busy[d]));
    cmp("done", d, int'(done), int'(e_done[d]));
    cmp("cs_n", d, int'(cs_n), int'(e_csn[d]));
    if (cs_n) cmp("sclk_idle", d, int'(sclk), 0);
    if (!cs_n && !in_fr[d]) begin
      in_fr[d] = 1'b1;
      nb[d]    = 0;
      bits[d]  = '0;
      psclk[d] = 1'b0;
    end
    if (in_fr[d] && !cs_n) begin
      if (sclk && !psclk[d]) begin
        bits[d] = {bits[d][14:0], mosi};
        nb[d]++;
      end
      psclk[d] = sclk;
    end else if (in_fr[d] && cs_n) begin
      in_fr[d] = 1'b0;
      cmp("sclk_rises", d, nb[d], 16);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        cmp("unexpected_frame", d, int'(bits[d]), -1);
      end else begin
        exp = (d == 0) ? q0.pop_front() : q1.pop_front();
        cmp("frame", d, int'(bits[d]), int'(exp));
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, rst0, w0, H0, CMD0);
    model_step(1, rst1, w1, H1, CMD1);
  end

  always @(negedge clk) begin
    monitor(0, cs_n0, sclk0, mosi0, busy0, done0);
    monitor(1, cs_n1, sclk1, mosi1, busy1, done1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   rises;
    logic prev;
    logic [7:0] old;

    tick(3);
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick(80);                  // first frames 16'h1180 / 16'hA53C
    tick(300);                 // quiet period
    w0 = 8'd129;
    w1 = 8'($urandom);
    tick(20);
    w0 = 8'd130;
    tick(10);
    w0 = 8'd50;
    tick(200);                 // 16'h1181 then one coalesced 16'h1132

    // Reset after the 7th SCLK rising edge of a new frame
    w0    = 8'd77;
    rises = 0;
    prev  = sclk0;
    for (int i = 0; i < 200 && rises < 7; i++) begin
      tick(1);
      if (sclk0 && !prev) rises++;
      prev = sclk0;
    end
    cmp("sclk_wait", 0, rises, 7);
    rst0 = 1'b1;
    tick(1);
    rst0 = 1'b0;
    tick(120);

    // Randomised traffic, including bounce-back and occasional resets
    for (int i = 0; i < 40; i++) begin
      old = w0;
      if ($urandom_range(0, 3) != 0) w0 = 8'($urandom);
      if ($urandom_range(0, 3) != 0) w1 = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        tick($urandom_range(1, 6));
        w0 = old;
      end
      rst0 = ($urandom_range(0, 11) == 0);
      rst1 = ($urandom_range(0, 11) == 0);
      tick(1);
      rst0 = 1'b0;
      rst1 = 1'b0;
      tick($urandom_range(1, 90));
    end

    tick(200);
    cmp("pending_frames0", 0, q0.size(), 0);
    cmp("pending_frames1", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digi_pot_spi_writer.md
# digi_pot_spi_writer

Serialises the 8-bit wiper value produced by `digi_pot` (its `resistance_out`) onto a 3-wire SPI link to an external digital-potentiometer chip. It watches `wiper_in` and sends one 16-bit frame, a command byte followed by a data byte, whenever the value differs from the last value sent. Intermediate values that arrive during a frame are coalesced, so only the latest one is sent next. It is the downstream stage of `digi_pot`.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles (H). Legal range 1..65535.
- `CMD_BYTE`, default 8'h11: command byte sent as frame bits [15:8].

Ports:
- `clk`, input, 1: single system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `wiper_in`, input, 8: wiper value, driven from `digi_pot.resistance_out`.
- `sclk`, output, 1: SPI clock, mode 0 (idles low, data sampled on rising edge).
- `mosi`, output, 1: serial data, MSB first.
- `cs_n`, output, 1: chip select, active low.
- `busy`, output, 1: high while a frame or its post-frame gap is in progress.
- `done`, output, 1: one-cycle pulse when a frame and its gap complete.

## Operation
- Registers:
  - `last_sent[7:0]`: the value most recently sent.
  - `init_pend`: set by reset; forces one frame after reset.
  - `shadow[15:0]`: the frame being shifted.
  - bit counter `[4:0]`.
  - divider counter `[15:0]`.
- Reset values:
  - `cs_n` = 1, `sclk` = 0, `mosi` = 0, `busy` = 0, `done` = 0.
  - `last_sent` = 0, `init_pend` = 1, state = IDLE.
- Start condition: state is IDLE and (`init_pend` or `wiper_in != last_sent`). On that edge:
  - `shadow <= {CMD_BYTE, wiper_in}` and `last_sent <= wiper_in`.
  - clear `init_pend`.
  - `cs_n <= 0`, `busy <= 1`, `mosi <= CMD_BYTE[7]`.
  - go to SETUP.
- State machine:
  - IDLE: `cs_n` = 1, `sclk` = 0. Wait for the start condition.
  - SETUP: H cycles with `sclk` low and `mosi` = bit 15. Then go to SHIFT_HI.
  - SHIFT_HI: H cycles with `sclk` high; `mosi` stays stable.
    - If more bits remain: go to SHIFT_LO and drive the next bit on `mosi` on the transition edge.
    - After bit 0: go to HOLD.
  - SHIFT_LO: H cycles with `sclk` low. Then go to SHIFT_HI.
  - HOLD: H cycles with `sclk` low and `cs_n` still low. Then `cs_n <= 1`, `mosi <= 0`, go to GAP.
  - GAP: H cycles with `cs_n` high. On the last cycle, `done` = 1 for one cycle and `busy` drops on the same edge. Go to IDLE.
- `wiper_in` is sampled only at the start condition. Changes during a frame do not alter the frame in flight.
- Coalescing: after GAP, the start condition is re-evaluated against the current `wiper_in`. Any number of changes during a frame produce at most one follow-up frame, carrying the latest value.
- A value that changes and then returns to `last_sent` before IDLE produces no frame.
- Reset mid-frame aborts immediately on the next edge (all outputs take their reset values) with no partial `done`. Because `init_pend` is set, the current value is re-sent after release.

## Timing
- Latency: a `wiper_in` change registered while IDLE causes `cs_n` to fall on the next rising edge (1 cycle).
- `cs_n` low time = H (SETUP) + 16×2H − H + H (HOLD) = 33H cycles.
- SCLK: 16 rising edges per frame, period 2H. `mosi` changes only while `sclk` is low, at least H cycles before each rising edge.
- Frame-to-frame `cs_n` high time ≥ H + 1 cycles, counting GAP plus the IDLE evaluation cycle.
- `busy` spans from the `cs_n` fall through the last GAP cycle: 34H cycles.
- First frame after reset: `cs_n` falls on the first edge at which `reset` is sampled low.

## Test plan
- CLK_DIV=2, `wiper_in`=128 through reset → first frame begins one edge after release. `cs_n` is low for 66 cycles; the bits sampled on SCLK rising edges read 16'h1180. Exactly one `done` pulse.
- After the first frame, hold `wiper_in` constant for 300 cycles → `cs_n` stays high, `sclk` stays 0, `busy` stays 0.
- `wiper_in` 128→129 while IDLE → `cs_n` falls 1 cycle later; frame 16'h1181; `done` 68 cycles after the `cs_n` fall.
- During the 8'd129 frame, drive 130 and then 50 → the 16'h1181 frame completes unaltered. Exactly one following frame, 16'h1132, then idle.
- Assert `reset` for 1 cycle after the 7th SCLK rising edge → next edge gives `cs_n`=1, `sclk`=0, `busy`=0, no `done`. After release, a full 16'h11xx frame carries the current `wiper_in`.
- CLK_DIV=1, `CMD_BYTE`=8'hA5, `wiper_in`=8'h3C → SCLK period 2 cycles; `cs_n` low 33 cycles; frame 16'hA53C.
